// File: rtl/sha_sched_pkg.sv
// Shared definitions for the SHA-256 nonce scheduler.
// Contents:
//   - word offsets (wbs_adr_i[4:2]) of the eight registers in the window
//   - CTRL and STATUS bit positions
//   - scheduler FSM state encoding
//   - saturating 32-bit increment used by the job counter
package sha_sched_pkg;

    localparam logic [2:0] REG_CTRL        = 3'd0;  // 0x00
    localparam logic [2:0] REG_STATUS      = 3'd1;  // 0x04
    localparam logic [2:0] REG_NONCE_START = 3'd2;  // 0x08
    localparam logic [2:0] REG_NONCE_END   = 3'd3;  // 0x0C
    localparam logic [2:0] REG_TARGET      = 3'd4;  // 0x10
    localparam logic [2:0] REG_NONCE_CUR   = 3'd5;  // 0x14
    localparam logic [2:0] REG_FOUND_NONCE = 3'd6;  // 0x18
    localparam logic [2:0] REG_HASH_CNT    = 3'd7;  // 0x1C

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FOUND     = 1;
    localparam int STAT_EXHAUSTED = 2;
    localparam int STAT_TIMEOUT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } sched_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sha_sched_wb_regs.sv
// Wishbone classic slave and register file of the nonce scheduler.
// Ports:
//   wb_clk_i, wb_rstn_i        clock, synchronous active-low reset
//   wbs_*                      Wishbone slave interface (single-cycle ack)
//   busy/found/exhausted/timeout, nonce_cur, found_nonce, hash_cnt
//                              status from the scheduler core (read-only)
//   start_pulse, abort_pulse   combinational one-cycle pulses on the decode
//                              cycle of a CTRL write with bit0/bit1 set
//   irq_en, nonce_start, nonce_end, target
//                              firmware-programmed configuration
module sha_sched_wb_regs
    import sha_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic        busy,
    input  logic        found,
    input  logic        exhausted,
    input  logic        timeout,
    input  logic [31:0] nonce_cur,
    input  logic [31:0] found_nonce,
    input  logic [31:0] hash_cnt,
    output logic        start_pulse,
    output logic        abort_pulse,
    output logic        irq_en,
    output logic [31:0] nonce_start,
    output logic [31:0] nonce_end,
    output logic [31:0] target
);

    logic        ack_reg, ack_next;
    logic [31:0] dat_reg, dat_next;
    logic        irq_en_reg, irq_en_next;
    logic [31:0] nonce_start_reg, nonce_start_next;
    logic [31:0] nonce_end_reg, nonce_end_next;
    logic [31:0] target_reg, target_next;

    logic        addr_hit;
    logic        req;
    logic        wr_req;
    logic [2:0]  offset;
    logic [31:0] byte_mask;
    logic [31:0] rd_data;

    // Byte lanes 1:0 of the address are don't-care for word registers.
    logic unused_adr_lsb;
    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign addr_hit = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
    // The !ack term keeps a held strobe from producing back-to-back acks.
    assign req      = wbs_stb_i & wbs_cyc_i & ~ack_reg & addr_hit;
    assign wr_req   = req & wbs_we_i;
    assign offset   = wbs_adr_i[4:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    // Pulses fire on the decode cycle so the FSM sees the same busy value
    // the register file used to accept or discard the access.
    assign start_pulse = wr_req & (offset == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
    assign abort_pulse = wr_req & (offset == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_ABORT];

    always_comb begin
        rd_data = 32'd0;
        case (offset)
            REG_CTRL:        rd_data[CTRL_IRQ_EN] = irq_en_reg;
            REG_STATUS:      rd_data[3:0] = {timeout, exhausted, found, busy};
            REG_NONCE_START: rd_data = nonce_start_reg;
            REG_NONCE_END:   rd_data = nonce_end_reg;
            REG_TARGET:      rd_data = target_reg;
            REG_NONCE_CUR:   rd_data = nonce_cur;
            REG_FOUND_NONCE: rd_data = found_nonce;
            REG_HASH_CNT:    rd_data = hash_cnt;
            default:         rd_data = 32'd0;
        endcase
    end

    always_comb begin
        ack_next         = req;
        dat_next         = req ? rd_data : dat_reg;
        irq_en_next      = irq_en_reg;
        nonce_start_next = nonce_start_reg;
        nonce_end_next   = nonce_end_reg;
        target_next      = target_reg;
        if (wr_req) begin
            case (offset)
                REG_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        irq_en_next = wbs_dat_i[CTRL_IRQ_EN];
                    end
                end
                REG_NONCE_START: begin
                    if (!busy) begin
                        nonce_start_next = (nonce_start_reg & ~byte_mask) | (wbs_dat_i & byte_mask);
                    end
                end
                REG_NONCE_END: begin
                    if (!busy) begin
                        nonce_end_next = (nonce_end_reg & ~byte_mask) | (wbs_dat_i & byte_mask);
                    end
                end
                REG_TARGET: begin
                    if (!busy) begin
                        target_next = (target_reg & ~byte_mask) | (wbs_dat_i & byte_mask);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            ack_reg         <= 1'b0;
            dat_reg         <= 32'd0;
            irq_en_reg      <= 1'b0;
            nonce_start_reg <= 32'd0;
            nonce_end_reg   <= 32'd0;
            target_reg      <= 32'd0;
        end else begin
            ack_reg         <= ack_next;
            dat_reg         <= dat_next;
            irq_en_reg      <= irq_en_next;
            nonce_start_reg <= nonce_start_next;
            nonce_end_reg   <= nonce_end_next;
            target_reg      <= target_next;
        end
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign irq_en      = irq_en_reg;
    assign nonce_start = nonce_start_reg;
    assign nonce_end   = nonce_end_reg;
    assign target      = target_reg;

endmodule

// File: rtl/sha_nonce_scheduler.sv
// SHA-256 mining job scheduler.
// Walks NONCE_START..NONCE_END, launching one hash-core job per nonce and
// comparing the most-significant hash word against TARGET. Stops on the
// first hit, on range exhaustion, on abort or on a core timeout.
// Ports:
//   wb_clk_i, wb_rstn_i     clock, synchronous active-low reset
//   wbs_*                   Wishbone slave (register window at BASE_ADR)
//   core_start, core_nonce  job launch pulse and nonce to the hash core
//   core_done, core_hash_msw  job completion pulse and result word
//   irq                     level IRQ (found|exhausted|timeout) & irq_en
//   status_o                {timeout, exhausted, found, busy}
module sha_nonce_scheduler
    import sha_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
    parameter int          CORE_TIMEOUT = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        core_start,
    output logic [31:0] core_nonce,
    input  logic        core_done,
    input  logic [31:0] core_hash_msw,
    output logic        irq,
    output logic [3:0]  status_o
);

    localparam int TMO_W = $clog2(CORE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CORE_TIMEOUT - 1);

    sched_state_t state_reg, state_next;
    logic [31:0]  nonce_cur_reg, nonce_cur_next;
    logic [31:0]  found_nonce_reg, found_nonce_next;
    logic [31:0]  hash_msw_reg, hash_msw_next;
    logic [31:0]  hash_cnt_reg, hash_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic         found_reg, found_next;
    logic         exhausted_reg, exhausted_next;
    logic         timeout_reg, timeout_next;
    logic         abort_pending_reg, abort_pending_next;

    logic         busy;
    logic         start_pulse;
    logic         abort_pulse;
    logic         irq_en;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [31:0]  target;

    assign busy = (state_reg != ST_IDLE);

    sha_sched_wb_regs #(
        .BASE_ADR (BASE_ADR)
    ) u_regs (
        .wb_clk_i    (wb_clk_i),
        .wb_rstn_i   (wb_rstn_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_ack_o   (wbs_ack_o),
        .busy        (busy),
        .found       (found_reg),
        .exhausted   (exhausted_reg),
        .timeout     (timeout_reg),
        .nonce_cur   (nonce_cur_reg),
        .found_nonce (found_nonce_reg),
        .hash_cnt    (hash_cnt_reg),
        .start_pulse (start_pulse),
        .abort_pulse (abort_pulse),
        .irq_en      (irq_en),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_reg         <= ST_IDLE;
            nonce_cur_reg     <= 32'd0;
            found_nonce_reg   <= 32'd0;
            hash_msw_reg      <= 32'd0;
            hash_cnt_reg      <= 32'd0;
            tmo_cnt_reg       <= '0;
            found_reg         <= 1'b0;
            exhausted_reg     <= 1'b0;
            timeout_reg       <= 1'b0;
            abort_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            nonce_cur_reg     <= nonce_cur_next;
            found_nonce_reg   <= found_nonce_next;
            hash_msw_reg      <= hash_msw_next;
            hash_cnt_reg      <= hash_cnt_next;
            tmo_cnt_reg       <= tmo_cnt_next;
            found_reg         <= found_next;
            exhausted_reg     <= exhausted_next;
            timeout_reg       <= timeout_next;
            abort_pending_reg <= abort_pending_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        nonce_cur_next     = nonce_cur_reg;
        found_nonce_next   = found_nonce_reg;
        hash_msw_next      = hash_msw_reg;
        hash_cnt_next      = hash_cnt_reg;
        tmo_cnt_next       = tmo_cnt_reg;
        found_next         = found_reg;
        exhausted_next     = exhausted_reg;
        timeout_next       = timeout_reg;
        abort_pending_next = abort_pending_reg;
        core_start         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Outside IDLE a start is dropped entirely, flags included.
                if (start_pulse) begin
                    found_next     = 1'b0;
                    timeout_next   = 1'b0;
                    hash_cnt_next  = 32'd0;
                    if (nonce_end < nonce_start) begin
                        exhausted_next = 1'b1;
                    end else begin
                        exhausted_next = 1'b0;
                        nonce_cur_next = nonce_start;
                        state_next     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                core_start   = 1'b1;
                tmo_cnt_next = '0;
                state_next   = ST_WAIT;
                if (abort_pulse) begin
                    abort_pending_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (abort_pulse) begin
                    abort_pending_next = 1'b1;
                end
                // A done in the last allowed cycle still counts as a completion.
                if (core_done) begin
                    hash_msw_next = core_hash_msw;
                    hash_cnt_next = sat_inc32(hash_cnt_reg);
                    state_next    = ST_CHECK;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_CHECK: begin
                if (hash_msw_reg <= target) begin
                    found_nonce_next = nonce_cur_reg;
                    found_next       = 1'b1;
                    state_next       = ST_IDLE;
                end else if (abort_pending_reg) begin
                    state_next = ST_IDLE;
                end else if (nonce_cur_reg == nonce_end) begin
                    // Compare before increment so 0xFFFFFFFF never wraps to 0.
                    exhausted_next = 1'b1;
                    state_next     = ST_IDLE;
                end else begin
                    nonce_cur_next = nonce_cur_reg + 32'd1;
                    state_next     = ST_ISSUE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next == ST_IDLE) begin
            abort_pending_next = 1'b0;
        end
    end

    assign core_nonce = nonce_cur_reg;
    assign status_o   = {timeout_reg, exhausted_reg, found_reg, busy};
    assign irq        = irq_en & (found_reg | exhausted_reg | timeout_reg);

endmodule
